// File: rtl/kappa3_dbg_pkg.sv
// Shared types and constants for the kappa3-light debug port: memory FSM
// encoding, strobe bit positions and default bus widths.
package kappa3_dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    localparam int STB_PC  = 0;
    localparam int STB_IR  = 1;
    localparam int STB_REG = 2;
    localparam int STB_A   = 3;
    localparam int STB_B   = 4;
    localparam int STB_C   = 5;
    localparam int STB_MRD = 6;
    localparam int STB_MWR = 7;
    localparam int NUM_STB = 8;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/kappa3_dbg_port_if.sv
// Word memory bus between the debug port (master) and the memory arbiter.
// Handshake: req rises with addr/we/wdata valid and holds them stable until
// the cycle ack is high; rdata is valid only in that ack cycle.
interface kappa3_dbg_port_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/dbg_edge_det.sv
// Rising-edge detector for a vector of level strobes. rise is combinational
// for same-edge data capture; pulse is its registered one-cycle copy.
module dbg_edge_det #(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         gate,
    input  logic [N-1:0] strobe,
    output logic [N-1:0] rise,
    output logic [N-1:0] pulse
);
    logic [N-1:0] hist;

    // History updates even when gated so a strobe held across the gate is swallowed.
    assign rise = strobe & ~hist & {N{gate}};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hist  <= '0;
            pulse <= '0;
        end else begin
            hist  <= strobe;
            pulse <= rise;
        end
    end
endmodule

// File: rtl/kappa3_dbg_port.sv
// Debug responder: turns host level strobes into datapath load pulses and
// runs single word memory accesses with an ack timeout.
module kappa3_dbg_port
    import kappa3_dbg_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               running,
    input  logic [DATA_W-1:0]  dbg_in,
    input  logic               dbg_pc_ld,
    input  logic               dbg_ir_ld,
    input  logic               dbg_reg_ld,
    input  logic               dbg_a_ld,
    input  logic               dbg_b_ld,
    input  logic               dbg_c_ld,
    input  logic [4:0]         dbg_reg_addr,
    input  logic [ADDR_W-1:0]  dbg_mem_addr,
    input  logic               dbg_mem_read,
    input  logic               dbg_mem_write,
    output logic               pc_ld,
    output logic               ir_ld,
    output logic               reg_ld,
    output logic               a_ld,
    output logic               b_ld,
    output logic               c_ld,
    output logic [DATA_W-1:0]  ld_data,
    output logic [4:0]         reg_waddr,
    kappa3_dbg_port_if.master  mem,
    output logic [DATA_W-1:0]  dbg_mem_out,
    output logic               busy,
    output logic               err,
    output mem_state_e         fsm_state
);
    localparam int CNT_W = $clog2(TIMEOUT);

    logic [NUM_STB-1:0] strobe, rise, pulse;
    logic [5:0]         ld_q;
    logic [ADDR_W-1:0]  st_addr, addr_q;
    logic [DATA_W-1:0]  st_data, wdata_q;
    logic               we_q;
    logic [CNT_W-1:0]   cnt;
    mem_state_e         state, state_nx;
    logic               mem_go, aligned, tmo_hit;
    logic               req_c, issue, set_err, rd_done;

    assign strobe = {dbg_mem_write, dbg_mem_read, dbg_c_ld, dbg_b_ld,
                     dbg_a_ld, dbg_reg_ld, dbg_ir_ld, dbg_pc_ld};

    dbg_edge_det #(.N(NUM_STB)) u_edge (
        .clock  (clock),
        .reset  (reset),
        .gate   (~running),
        .strobe (strobe),
        .rise   (rise),
        .pulse  (pulse)
    );

    assign mem_go  = pulse[STB_MRD] | pulse[STB_MWR];
    assign aligned = (st_addr[1:0] == 2'b00);
    assign tmo_hit = (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (mem_go && aligned) state_nx = ST_REQ;
            ST_REQ:  if (mem.ack || tmo_hit) state_nx = ST_DONE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        req_c   = (state == ST_REQ);
        issue   = 1'b0;
        set_err = 1'b0;
        rd_done = 1'b0;
        case (state)
            ST_IDLE: begin
                issue   = mem_go & aligned;
                set_err = mem_go & ~aligned;
            end
            ST_REQ: begin
                rd_done = mem.ack & ~we_q;
                set_err = ~mem.ack & tmo_hit;
            end
            default: ;
        endcase
        if (mem_go && state != ST_IDLE) set_err = 1'b1;
        if (pulse[STB_MRD] && pulse[STB_MWR]) set_err = 1'b1;
    end

    // Load data and memory operands are snapshotted on the strobe edge itself.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ld_q        <= '0;
            ld_data     <= '0;
            reg_waddr   <= '0;
            st_addr     <= '0;
            st_data     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            cnt         <= '0;
            dbg_mem_out <= '0;
            err         <= 1'b0;
        end else begin
            ld_q <= pulse[5:0];
            if (|rise[5:0])   ld_data   <= dbg_in;
            if (rise[STB_REG]) reg_waddr <= dbg_reg_addr;
            if (rise[STB_MRD] || rise[STB_MWR]) begin
                st_addr <= dbg_mem_addr;
                st_data <= dbg_in;
            end
            if (issue) begin
                addr_q  <= st_addr;
                wdata_q <= st_data;
                we_q    <= pulse[STB_MWR];
            end
            cnt <= (state == ST_REQ) ? cnt + 1'b1 : '0;
            if (rd_done) dbg_mem_out <= mem.rdata;
            if (set_err) err <= 1'b1;
        end
    end

    assign {c_ld, b_ld, a_ld, reg_ld, ir_ld, pc_ld} = ld_q;
    assign mem.req   = req_c;
    assign mem.we    = we_q;
    assign mem.addr  = addr_q;
    assign mem.wdata = wdata_q;
    assign busy      = (state != ST_IDLE);
    assign fsm_state = state;
endmodule

// File: tb/tb_kappa3_dbg_port.sv
// Directed bench for kappa3_dbg_port: load pulses, memory handshake,
// misalignment, timeout, running gate and busy collisions.
module tb_kappa3_dbg_port;
    import kappa3_dbg_pkg::*;

    logic        clock, reset, running;
    logic [31:0] dbg_in, dbg_mem_addr, ld_data, dbg_mem_out;
    logic        dbg_pc_ld, dbg_ir_ld, dbg_reg_ld, dbg_a_ld, dbg_b_ld, dbg_c_ld;
    logic [4:0]  dbg_reg_addr, reg_waddr;
    logic        dbg_mem_read, dbg_mem_write;
    logic        pc_ld, ir_ld, reg_ld, a_ld, b_ld, c_ld, busy, err;
    mem_state_e  fsm_state;

    int          n_checks, n_pass, hits;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd;

    kappa3_dbg_port_if #(.DATA_W(32), .ADDR_W(32)) mem_bus ();

    kappa3_dbg_port dut (
        .clock(clock), .reset(reset), .running(running), .dbg_in(dbg_in),
        .dbg_pc_ld(dbg_pc_ld), .dbg_ir_ld(dbg_ir_ld), .dbg_reg_ld(dbg_reg_ld),
        .dbg_a_ld(dbg_a_ld), .dbg_b_ld(dbg_b_ld), .dbg_c_ld(dbg_c_ld),
        .dbg_reg_addr(dbg_reg_addr), .dbg_mem_addr(dbg_mem_addr),
        .dbg_mem_read(dbg_mem_read), .dbg_mem_write(dbg_mem_write),
        .pc_ld(pc_ld), .ir_ld(ir_ld), .reg_ld(reg_ld), .a_ld(a_ld), .b_ld(b_ld),
        .c_ld(c_ld), .ld_data(ld_data), .reg_waddr(reg_waddr), .mem(mem_bus.master),
        .dbg_mem_out(dbg_mem_out), .busy(busy), .err(err), .fsm_state(fsm_state)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Drivers
    task automatic mem_strobe(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] data);
        dbg_mem_addr  = addr;
        dbg_in        = data;
        dbg_mem_read  = rd;
        dbg_mem_write = wr;
        tick();
        dbg_mem_read  = 1'b0;
        dbg_mem_write = 1'b0;
        tick();
    endtask

    task automatic ack_once(input logic [31:0] rdata);
        mem_bus.ack   = 1'b1;
        mem_bus.rdata = rdata;
        tick();
        mem_bus.ack   = 1'b0;
        mem_bus.rdata = 32'h0;
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        running = 0; dbg_in = 0; dbg_mem_addr = 0; dbg_reg_addr = 0;
        {dbg_pc_ld, dbg_ir_ld, dbg_reg_ld, dbg_a_ld, dbg_b_ld, dbg_c_ld} = '0;
        dbg_mem_read = 0; dbg_mem_write = 0;
        mem_bus.ack = 0; mem_bus.rdata = 0;
        reset = 1'b1;
        tick(); tick();
        check("rst_ld", {pc_ld, ir_ld, reg_ld, a_ld, b_ld, c_ld}, 0);
        check("rst_outs", {mem_bus.req, busy, err, ld_data, dbg_mem_out}, 0);
        check("rst_state", fsm_state, ST_IDLE);
        reset = 1'b0;
        tick();

        // PC load held high: one pulse, one cycle after sampling
        dbg_in = 32'h0000_0100; dbg_pc_ld = 1'b1;
        tick();
        check("pc_ld_k", pc_ld, 0);
        check("ld_data_pc", ld_data, 32'h100);
        tick();
        check("pc_ld_k1", pc_ld, 1);
        tick();
        check("pc_ld_k2", pc_ld, 0);
        hits = 0;
        repeat (4) begin tick(); hits += int'(pc_ld); end
        check("pc_ld_hold", hits, 0);
        dbg_pc_ld = 1'b0; tick();

        // Register load with index
        dbg_reg_addr = 5'd3; dbg_in = 32'hDEAD_BEEF; dbg_reg_ld = 1'b1;
        tick();
        dbg_reg_ld = 1'b0; dbg_in = 32'h0;
        tick();
        check("reg_ld", reg_ld, 1);
        check("reg_waddr", reg_waddr, 3);
        check("ld_data_reg", ld_data, 32'hDEAD_BEEF);
        check("others_ld", {pc_ld, ir_ld, a_ld, b_ld, c_ld}, 0);
        tick();

        // Simultaneous A and B loads share ld_data
        dbg_in = 32'h0000_0055; dbg_a_ld = 1'b1; dbg_b_ld = 1'b1;
        tick();
        dbg_a_ld = 1'b0; dbg_b_ld = 1'b0;
        tick();
        check("ab_ld", {a_ld, b_ld, c_ld, pc_ld}, 4'b1100);
        check("ld_data_ab", ld_data, 32'h55);
        tick();

        // Write 0x12345678 at 0x8, acked on the third REQ edge
        mem_strobe(1'b0, 1'b1, 32'h8, 32'h1234_5678);
        check("wr_req", {mem_bus.req, mem_bus.we, busy}, 3'b111);
        check("wr_state", fsm_state, ST_REQ);
        dbg_in = 32'h0; dbg_mem_addr = 32'hFFFF_FFF0;
        tick();
        check("wr_fields1", {mem_bus.req, mem_bus.addr, mem_bus.wdata}, {1'b1, 32'h8, 32'h1234_5678});
        tick();
        check("wr_fields2", {mem_bus.req, mem_bus.we, mem_bus.addr}, {1'b1, 1'b1, 32'h8});
        ack_once(32'h0000_0BAD);
        check("wr_done", {mem_bus.req, busy}, 2'b01);
        check("wr_state_done", fsm_state, ST_DONE);
        check("wr_no_rdata", dbg_mem_out, 32'h0);
        tick();
        check("wr_idle", busy, 0);

        // Read back from 0x8
        exp_q.push_back(32'h1234_5678);
        mem_strobe(1'b1, 1'b0, 32'h8, 32'h0);
        check("rd_req", {mem_bus.req, mem_bus.we, mem_bus.addr}, {1'b1, 1'b0, 32'h8});
        ack_once(32'h1234_5678);
        last_rd = exp_q.pop_front();
        check("rd_data", dbg_mem_out, last_rd);
        check("rd_err", err, 0);
        tick();

        // Misaligned read, then async reset mid-cycle
        mem_strobe(1'b1, 1'b0, 32'h6, 32'h0);
        check("mis_req", {mem_bus.req, busy}, 2'b00);
        check("mis_err", err, 1);
        tick();
        check("mis_busy", busy, 0);
        #2 reset = 1'b1;
        #1 check("rst_async_err", err, 0);
        reset = 1'b0;
        tick();

        // Good read, then a read that never gets acked
        exp_q.push_back(32'hCAFE_0001);
        mem_strobe(1'b1, 1'b0, 32'h10, 32'h0);
        ack_once(32'hCAFE_0001);
        last_rd = exp_q.pop_front();
        check("rd2_data", dbg_mem_out, last_rd);
        tick();
        mem_strobe(1'b1, 1'b0, 32'h20, 32'h0);
        hits = 0;
        while (mem_bus.req && hits < 40) begin hits++; tick(); end
        check("tmo_cycles", hits, 16);
        check("tmo_err", err, 1);
        check("tmo_keep", dbg_mem_out, 32'hCAFE_0001);
        check("tmo_state", fsm_state, ST_DONE);
        tick();
        check("tmo_idle", busy, 0);
        do_reset();

        // running gates strobes, and release while held gives nothing
        running = 1'b1; dbg_c_ld = 1'b1;
        tick(); tick();
        check("run_c_ld", c_ld, 0);
        running = 1'b0;
        hits = 0;
        repeat (3) begin tick(); hits += int'(c_ld); end
        check("run_release", hits, 0);
        dbg_c_ld = 1'b0; tick();

        // Read edge while a write is outstanding is dropped
        mem_strobe(1'b0, 1'b1, 32'h40, 32'h0000_A5A5);
        check("coll_wr_req", mem_bus.req, 1);
        dbg_mem_addr = 32'h44; dbg_mem_read = 1'b1;
        tick();
        dbg_mem_read = 1'b0;
        tick();
        check("coll_err", err, 1);
        check("coll_fields", {mem_bus.req, mem_bus.we, mem_bus.addr, mem_bus.wdata},
              {1'b1, 1'b1, 32'h40, 32'h0000_A5A5});
        ack_once(32'h0);
        check("coll_wr_done", mem_bus.req, 0);
        tick(); tick();
        check("coll_no_rd", {mem_bus.req, busy}, 2'b00);
        do_reset();

        // Read and write edges together: write wins, err set
        mem_strobe(1'b1, 1'b1, 32'h50, 32'h0000_0777);
        check("both_we", {mem_bus.req, mem_bus.we, mem_bus.addr}, {1'b1, 1'b1, 32'h50});
        check("both_err", err, 1);
        ack_once(32'h0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
